// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : VGA raster timing generator. Divides the system clock down to
//               a pixel strobe, scans horizontal/vertical pixel counters over
//               a full frame and decodes sync, active-video and frame tick.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int PIX_DIV  = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_stb,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Last counter values before wrap; the reset values park the scan here so
  // that the first pixel strobe lands exactly on (0,0).
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Region boundaries held at 11 bits so a sync pulse ending exactly at the
  // line/frame total still compares correctly against a 10-bit counter.
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  // High on the last system clock of each pixel period.
  logic wrap;

  if (PIX_DIV > 1) begin : g_div_multi
    localparam int DIV_W = $clog2(PIX_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_cnt;

    // Pixel clock divider counting 0..PIX_DIV-1.
    always_ff @(posedge clock) begin
      if (reset) begin
        div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
    end

    assign wrap = (div_cnt == DIV_LAST);
  end else begin : g_div_single
    // One clock per pixel: every clock advances the scan.
    assign wrap = 1'b1;
  end

  logic [9:0] hcount_next;
  logic [9:0] vcount_next;
  logic [7:0] frame_next;
  logic       h_at_last;
  logic       v_at_last;

  // Next scan position; counters only move on a wrap clock.
  always_comb begin
    h_at_last   = (hcount == H_LAST);
    v_at_last   = (vcount == V_LAST);
    hcount_next = hcount;
    vcount_next = vcount;
    frame_next  = frame_count;
    if (wrap) begin
      if (h_at_last) begin
        hcount_next = '0;
        if (v_at_last) begin
          vcount_next = '0;
          frame_next  = frame_count + 8'd1;
        end else begin
          vcount_next = vcount + 10'd1;
        end
      end else begin
        hcount_next = hcount + 10'd1;
      end
    end
  end

  logic       enable_next;
  logic       hsync_next;
  logic       vsync_next;
  logic       frame_start_next;
  logic       h_in_sync;
  logic       v_in_sync;
  logic [10:0] h_ext;
  logic [10:0] v_ext;

  // Decode regions from the next position so the registered flags line up
  // with the registered counters in the same cycle.
  always_comb begin
    h_ext            = {1'b0, hcount_next};
    v_ext            = {1'b0, vcount_next};
    h_in_sync        = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    v_in_sync        = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
    enable_next      = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    hsync_next       = h_in_sync ? SYNC_POL : ~SYNC_POL;
    vsync_next       = v_in_sync ? SYNC_POL : ~SYNC_POL;
    frame_start_next = wrap && (hcount_next == 10'd0) && (vcount_next == 10'd0);
  end

  // Output registers; non-wrap clocks reload identical values, so nothing
  // but the strobes can change between pixel boundaries.
  always_ff @(posedge clock) begin
    if (reset) begin
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      frame_count <= 8'd0;
      enable      <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      pix_stb     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= hcount_next;
      vcount      <= vcount_next;
      frame_count <= frame_next;
      enable      <= enable_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      pix_stb     <= wrap;
      frame_start <= frame_start_next;
    end
  end

endmodule
`default_nettype wire
